vga_rect_blitter: RTL and testbench
===================================

# vga_rect_blitter

Memory-mapped rectangle-fill engine sitting directly upstream of the VGA framebuffer driver. The CPU writes one 32-bit command describing a rectangle and a 1-bit colour. The block then streams one pixel-write per clock into the driver's write port, using the driver's word format, until the rectangle is filled. A one-deep pending slot lets the CPU queue a second command while a fill is running.

## Interface
- WIDTH, 80, framebuffer columns (x range 0..WIDTH-1)
- HEIGHT, 60, framebuffer rows (y range 0..HEIGHT-1)

- clock_50  in  1  system clock; single clock domain
- reset  in  1  synchronous, active-high reset
- data  in  32  CPU command word
- chip_select  in  1  CPU bus select
- write_enable  in  1  CPU write strobe; a command is presented when chip_select & write_enable
- pix_data  out  32  driver write word: [13:8]=y, [7:1]=x, [0]=colour, all other bits 0
- pix_cs  out  1  driver chip_select
- pix_we  out  1  driver write_enable; always equal to pix_cs
- busy  out  1  fill in progress or pending slot occupied
- done  out  1  one-cycle pulse after the last pixel of a command is emitted
- overflow  out  1  sticky; set when a command is dropped

## Operation
- Command word fields: [6:0]=x0, [12:7]=y0, [19:13]=x1, [25:20]=y1, [26]=colour, [30:27] ignored, [31]=ctl.
- ctl=1 makes the word a control write. It clears overflow and does not enqueue a command.
- Accept rule for a write with ctl=0:
  - FSM in IDLE: the command loads directly into the active register.
  - FSM busy and pending slot empty: the command goes into the pending slot.
  - Pending slot full: the command is dropped and overflow is set to 1.
- Normalisation happens in the LOAD state:
  - Clamp x0 and x1 to WIDTH-1, and y0 and y1 to HEIGHT-1.
  - If x0>x1, swap them. If y0>y1, swap them.
- FSM states: IDLE, LOAD, FILL.
  - IDLE -> LOAD when a command is accepted.
  - LOAD -> FILL after one cycle. The cursor is set to (xs, ys) and the bounds are latched.
  - FILL emits one pixel per cycle in raster order, x fastest. After x reaches xe, x returns to xs and y increments.
  - FILL, last pixel (x=xe, y=ye) with pending valid -> LOAD. The pending command is promoted and the slot freed.
  - FILL, last pixel with pending empty -> IDLE.
- Pixel count per command is (xe-xs+1)*(ye-ys+1). A single-point command emits exactly 1 pixel.
- Cursor registers are 7-bit x and 6-bit y. Comparisons use normalised bounds, so the cursor never exceeds WIDTH-1 or HEIGHT-1.
- Simultaneous events:
  - CPU write in the same cycle the pending slot is promoted: the slot is treated as full, so the write is dropped and overflow is set.
  - ctl write in the same cycle as an overflow-setting event cannot occur, since a single write is either ctl or a command.

## Timing
- All outputs are registered.
- Reset values: pix_data=0, pix_cs=0, pix_we=0, busy=0, done=0, overflow=0, FSM=IDLE, pending empty.
- Reset mid-fill aborts immediately. No further pix_cs follows the reset edge, and the pending command is discarded.
- Latency: command sampled at edge k; LOAD during cycle k+1; first pix_cs=1 visible after edge k+2.
- pix_cs is high for exactly N consecutive cycles per command, with no gaps.
- Between back-to-back commands there is exactly one idle LOAD cycle with pix_cs=0.
- done is high for the one cycle immediately following the last pix_cs=1 cycle of each command.
- busy goes high the cycle after an accepted command. It goes low in the same cycle as the final done when no pending command remains.
- overflow rises the cycle after the dropping write. It falls the cycle after a ctl write.

## Test plan
- Single pixel: write x0=x1=5, y0=y1=3, colour=1 -> one pix_cs cycle with pix_data=0x0000_030B, then done=1, then busy=0.
- 3x2 fill: x 10..12, y 4..5, colour=1 -> 6 consecutive pix_cs cycles, in order (10,4), (11,4), (12,4), (10,5), (11,5), (12,5); first at edge k+2.
- Swapped and clamped: x0=100, x1=78, y0=59, y1=58 -> normalised to x 78..79, y 58..59; 4 pixels, first pix_data y=58, x=78.
- Queueing: issue a 4x1 fill, then two more commands while busy -> second runs after exactly one LOAD gap; third is dropped; overflow=1; a ctl write (data[31]=1) clears overflow.
- Reset mid-fill: assert reset during the 3rd pixel of a 10x1 fill with a pending command -> pix_cs=0 from the next cycle, busy=0, no done pulse, pending command never emitted.
- Colour 0 fill on 2x2 at (0,0) -> pix_data[0]=0 on all 4 writes; pix_data bits [31:14] always 0.

Source files
------------

// File: rtl/vga_rect_blitter.sv
// Rectangle-fill engine: takes one CPU command word and streams one pixel-write per
// clock into the VGA framebuffer driver's write port, with a one-deep pending slot.
module vga_rect_blitter #(
    parameter int unsigned WIDTH  = 80,
    parameter int unsigned HEIGHT = 60
) (
    input  logic        clock_50,
    input  logic        reset,
    input  logic [31:0] data,
    input  logic        chip_select,
    input  logic        write_enable,
    output logic [31:0] pix_data,
    output logic        pix_cs,
    output logic        pix_we,
    output logic        busy,
    output logic        done,
    output logic        overflow
);

    localparam logic [6:0] XMAX = 7'(WIDTH - 1);
    localparam logic [5:0] YMAX = 6'(HEIGHT - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FILL} state_e;

    typedef struct packed {
        logic       col;
        logic [5:0] y1;
        logic [6:0] x1;
        logic [5:0] y0;
        logic [6:0] x0;
    } cmd_t;

    state_e      state_q, state_d;
    cmd_t        act_q, act_d, pend_q, pend_d;
    logic        pend_vld_q, pend_vld_d;
    logic [6:0]  xs_q, xs_d, xe_q, xe_d, cx_q, cx_d;
    logic [5:0]  ys_q, ys_d, ye_q, ye_d, cy_q, cy_d;
    logic        col_q, col_d;
    logic [31:0] pix_data_q, pix_data_d;
    logic        pix_cs_q, pix_cs_d;
    logic        last_q, last_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;
    logic        ovf_q, ovf_d;

    logic        cmd_wr, ctl_wr, drop;
    logic [6:0]  ax0, ax1;
    logic [5:0]  ay0, ay1;
    logic        unused_bits;

    assign unused_bits = ^data[30:27];
    assign cmd_wr = chip_select & write_enable & ~data[31];
    assign ctl_wr = chip_select & write_enable &  data[31];

    assign ax0 = (act_q.x0 > XMAX) ? XMAX : act_q.x0;
    assign ax1 = (act_q.x1 > XMAX) ? XMAX : act_q.x1;
    assign ay0 = (act_q.y0 > YMAX) ? YMAX : act_q.y0;
    assign ay1 = (act_q.y1 > YMAX) ? YMAX : act_q.y1;

    always_comb begin
        state_d    = state_q;
        act_d      = act_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        xs_d       = xs_q;
        xe_d       = xe_q;
        ys_d       = ys_q;
        ye_d       = ye_q;
        cx_d       = cx_q;
        cy_d       = cy_q;
        col_d      = col_q;
        pix_cs_d   = 1'b0;
        pix_data_d = '0;
        last_d     = 1'b0;
        done_d     = last_q;
        drop       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_wr) begin
                    act_d   = cmd_t'(data[26:0]);
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                xs_d    = (ax0 > ax1) ? ax1 : ax0;
                xe_d    = (ax0 > ax1) ? ax0 : ax1;
                ys_d    = (ay0 > ay1) ? ay1 : ay0;
                ye_d    = (ay0 > ay1) ? ay0 : ay1;
                cx_d    = (ax0 > ax1) ? ax1 : ax0;
                cy_d    = (ay0 > ay1) ? ay1 : ay0;
                col_d   = act_q.col;
                state_d = S_FILL;
            end
            S_FILL: begin
                pix_cs_d   = 1'b1;
                pix_data_d = {18'b0, cy_q, cx_q, col_q};
                if (cx_q == xe_q) begin
                    cx_d = xs_q;
                    if (cy_q == ye_q) begin
                        last_d = 1'b1;
                        if (pend_vld_q) begin
                            act_d      = pend_q;
                            pend_vld_d = 1'b0;
                            state_d    = S_LOAD;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        cy_d = cy_q + 6'd1;
                    end
                end else begin
                    cx_d = cx_q + 7'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A full slot (including one being promoted this cycle) rejects the write.
        if (cmd_wr && state_q != S_IDLE) begin
            if (pend_vld_q) begin
                drop = 1'b1;
            end else begin
                pend_d     = cmd_t'(data[26:0]);
                pend_vld_d = 1'b1;
            end
        end

        ovf_d  = ctl_wr ? 1'b0 : (drop ? 1'b1 : ovf_q);
        // Holding busy through the final FILL edge keeps it aligned with done.
        busy_d = (state_d != S_IDLE) | pend_vld_d | (state_q == S_FILL);
    end

    always_ff @(posedge clock_50) begin
        if (reset) begin
            state_q    <= S_IDLE;
            act_q      <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            xs_q       <= '0;
            xe_q       <= '0;
            ys_q       <= '0;
            ye_q       <= '0;
            cx_q       <= '0;
            cy_q       <= '0;
            col_q      <= 1'b0;
            pix_data_q <= '0;
            pix_cs_q   <= 1'b0;
            last_q     <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            act_q      <= act_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            xs_q       <= xs_d;
            xe_q       <= xe_d;
            ys_q       <= ys_d;
            ye_q       <= ye_d;
            cx_q       <= cx_d;
            cy_q       <= cy_d;
            col_q      <= col_d;
            pix_data_q <= pix_data_d;
            pix_cs_q   <= pix_cs_d;
            last_q     <= last_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            ovf_q      <= ovf_d;
        end
    end

    assign pix_data = pix_data_q;
    assign pix_cs   = pix_cs_q;
    assign pix_we   = pix_cs_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_vga_rect_blitter.sv
// Directed bench for vga_rect_blitter: expected pixel words are queued when a command
// is issued and popped by a negedge monitor whenever the driver write strobe is high.
module tb_vga_rect_blitter;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] data;
    logic        chip_select;
    logic        write_enable;
    logic [31:0] pix_data;
    logic        pix_cs;
    logic        pix_we;
    logic        busy;
    logic        done;
    logic        overflow;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    vga_rect_blitter #(.WIDTH(80), .HEIGHT(60)) dut (
        .clock_50    (clk),
        .reset       (reset),
        .data        (data),
        .chip_select (chip_select),
        .write_enable(write_enable),
        .pix_data    (pix_data),
        .pix_cs      (pix_cs),
        .pix_we      (pix_we),
        .busy        (busy),
        .done        (done),
        .overflow    (overflow)
    );

    function automatic logic [31:0] mk(input int x0, input int y0, input int x1,
                                       input int y1, input int c);
        return {1'b0, 4'b0, c[0], y1[5:0], x1[6:0], y0[5:0], x0[6:0]};
    endfunction

    function automatic logic [31:0] pix(input int x, input int y, input int c);
        return {18'b0, y[5:0], x[6:0], c[0]};
    endfunction

    task automatic push_rect(input int xs, input int xe, input int ys, input int ye,
                             input int c);
        for (int y = ys; y <= ye; y++)
            for (int x = xs; x <= xe; x++)
                exp_q.push_back(pix(x, y, c));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [31:0] w);
        data         = w;
        chip_select  = 1'b1;
        write_enable = 1'b1;
    endtask

    task automatic idle_bus();
        chip_select  = 1'b0;
        write_enable = 1'b0;
        data         = '0;
    endtask

    // Issue one command from idle and check the full timing of an n-pixel fill.
    task automatic run_cmd(input logic [31:0] w, input int n);
        wr(w);
        tick();
        idle_bus();
        chk("busy_after_accept", 32'(busy), 32'd1);
        chk("cs_in_load", 32'(pix_cs), 32'd0);
        tick();
        chk("cs_before_first", 32'(pix_cs), 32'd0);
        for (int i = 0; i < n; i++) begin
            tick();
            chk("cs_during_fill", 32'(pix_cs), 32'd1);
            chk("done_during_fill", 32'(done), 32'd0);
        end
        tick();
        chk("cs_after_fill", 32'(pix_cs), 32'd0);
        chk("done_pulse", 32'(done), 32'd1);
        chk("busy_low_with_done", 32'(busy), 32'd0);
        tick();
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        logic [31:0] e;
        checks++;
        assert (pix_we === pix_cs) else begin
            failures++;
            $error("FAIL pix_we_eq_cs: observed=%b expected=%b", pix_we, pix_cs);
        end
        if (pix_cs === 1'b1) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                failures++;
                $error("FAIL pix_unexpected: observed=%h expected=no write", pix_data);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++;
                assert (pix_data === e) else begin
                    failures++;
                    $error("FAIL pix_data: observed=%h expected=%h", pix_data, e);
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        idle_bus();
        repeat (3) tick();
        chk("rst_pix_data", pix_data, 32'h0);
        chk("rst_pix_cs", 32'(pix_cs), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        reset = 1'b0;
        tick();

        // Single pixel: x=5, y=3, colour 1 -> 0x0000_030B
        exp_q.push_back(32'h0000_030B);
        run_cmd(mk(5, 3, 5, 3, 1), 1);

        // 3x2 fill, raster order
        push_rect(10, 12, 4, 5, 1);
        run_cmd(mk(10, 4, 12, 5, 1), 6);

        // Swapped and clamped -> x 78..79, y 58..59
        push_rect(78, 79, 58, 59, 1);
        run_cmd(mk(100, 59, 78, 58, 1), 4);

        // Colour 0, 2x2 at origin
        push_rect(0, 1, 0, 1, 0);
        run_cmd(mk(0, 0, 1, 1, 0), 4);

        // Queueing: A runs, B pends, C dropped
        push_rect(20, 23, 7, 7, 1);
        push_rect(30, 31, 8, 8, 0);
        wr(mk(20, 7, 23, 7, 1));
        tick();                                   // edge k
        wr(mk(30, 8, 31, 8, 0));
        chk("q_busy", 32'(busy), 32'd1);
        tick();                                   // k+1: B pending
        wr(mk(40, 9, 40, 9, 1));
        chk("q_cs_load", 32'(pix_cs), 32'd0);
        chk("q_no_ovf_yet", 32'(overflow), 32'd0);
        tick();                                   // k+2: C dropped
        idle_bus();
        chk("q_cs_first", 32'(pix_cs), 32'd1);
        chk("q_overflow_set", 32'(overflow), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("q_cs_a", 32'(pix_cs), 32'd1);
        end
        tick();                                   // LOAD gap
        chk("q_gap_cs", 32'(pix_cs), 32'd0);
        chk("q_done_a", 32'(done), 32'd1);
        chk("q_busy_gap", 32'(busy), 32'd1);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("q_cs_b", 32'(pix_cs), 32'd1);
            chk("q_done_b_low", 32'(done), 32'd0);
        end
        tick();
        chk("q_cs_end", 32'(pix_cs), 32'd0);
        chk("q_done_b", 32'(done), 32'd1);
        chk("q_busy_end", 32'(busy), 32'd0);
        chk("q_ovf_sticky", 32'(overflow), 32'd1);
        wr(32'h8000_0000);
        tick();
        idle_bus();
        chk("q_ovf_cleared", 32'(overflow), 32'd0);
        chk("q_ctl_not_cmd", 32'(busy), 32'd0);
        repeat (4) tick();
        chk("q_queue_empty", 32'(exp_q.size()), 32'd0);

        // Reset during 3rd pixel of a 10x1 fill with a pending command
        push_rect(0, 2, 20, 20, 1);
        wr(mk(0, 20, 9, 20, 1));
        tick();                                   // edge k
        wr(mk(50, 1, 50, 1, 1));
        tick();                                   // k+1: pending
        idle_bus();
        tick();                                   // pixel 1
        tick();                                   // pixel 2
        tick();                                   // pixel 3
        chk("r_cs_third", 32'(pix_cs), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("r_cs_cleared", 32'(pix_cs), 32'd0);
        chk("r_busy_cleared", 32'(busy), 32'd0);
        chk("r_no_done", 32'(done), 32'd0);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("r_quiet_cs", 32'(pix_cs), 32'd0);
            chk("r_quiet_done", 32'(done), 32'd0);
        end
        chk("r_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
